// File: rtl/bus_arbiter_if.sv
// Shared-bus interface between two masters, the arbiter and one slave.
// The arbiter connects through the slave modport; the masters and the bus slave drive through master.
interface bus_arbiter_if;
  logic        M0_Req;
  logic [31:0] M0_Addr;
  logic        M0_WE;
  logic        M0_Gnt;
  logic        M0_Done;
  logic        M0_Err;

  logic        M1_Req;
  logic [31:0] M1_Addr;
  logic        M1_WE;
  logic        M1_Gnt;
  logic        M1_Done;
  logic        M1_Err;

  logic [31:0] Bus_Addr;
  logic        Bus_WE;
  logic        Bus_Strobe;
  logic        Bus_Ready;

  modport slave (
    input  M0_Req, M0_Addr, M0_WE, M1_Req, M1_Addr, M1_WE, Bus_Ready,
    output M0_Gnt, M0_Done, M0_Err, M1_Gnt, M1_Done, M1_Err,
    output Bus_Addr, Bus_WE, Bus_Strobe
  );

  modport master (
    output M0_Req, M0_Addr, M0_WE, M1_Req, M1_Addr, M1_WE, Bus_Ready,
    input  M0_Gnt, M0_Done, M0_Err, M1_Gnt, M1_Done, M1_Err,
    input  Bus_Addr, Bus_WE, Bus_Strobe
  );
endinterface

// File: rtl/bus_arbiter.sv
// Two-master round-robin bus arbiter with address decode and registered outputs.
// Optional ACCESS timeout is enabled by defining ARB_TIMEOUT_EN.
module bus_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic          clk,
  input  logic          reset_n,
  bus_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t      state, state_d;
  logic        winner, winner_d;
  logic        ptr;
  logic [31:0] lat_addr, lat_addr_d;
  logic        lat_we, lat_we_d;
  logic        err, err_d;

  logic        sel;
  logic [31:0] sel_addr;
  logic        sel_we;
  logic        tmo_hit;

  logic [1:0]  gnt_d, gnt_q;
  logic [1:0]  done_d, done_q;
  logic [1:0]  merr_d, merr_q;
  logic [31:0] addr_d, addr_q;
  logic        we_d, we_q;
  logic        strobe_d, strobe_q;

  // MEM occupies the low 8 KiB; TC, UART and GPIO are three 4 KiB pages at FFFF_0000h.
  function automatic logic addr_valid(input logic [31:0] a);
    return (a[31:13] == 19'd0) ||
           (a[31:12] == 20'hFFFF0) || (a[31:12] == 20'hFFFF1) || (a[31:12] == 20'hFFFF2);
  endfunction

  // ptr=1 favours M1 when both request; a lone request always wins.
  assign sel      = bus.M1_Req & (~bus.M0_Req | ptr);
  assign sel_addr = sel ? bus.M1_Addr : bus.M0_Addr;
  assign sel_we   = sel ? bus.M1_WE   : bus.M0_WE;

`ifdef ARB_TIMEOUT_EN
  logic [7:0] tmo_cnt;

  assign tmo_hit = (tmo_cnt == 8'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      tmo_cnt <= 8'd0;
    else if (state != ACCESS)
      tmo_cnt <= 8'd0;
    else
      tmo_cnt <= tmo_cnt + 8'd1;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      winner   <= 1'b0;
      ptr      <= 1'b0;
      lat_addr <= 32'd0;
      lat_we   <= 1'b0;
      err      <= 1'b0;
    end else begin
      state    <= state_d;
      winner   <= winner_d;
      lat_addr <= lat_addr_d;
      lat_we   <= lat_we_d;
      err      <= err_d;
      if (state == RESP)
        ptr <= ~winner;
    end
  end

  // NOTE: every comb output is defaulted first so no path leaves a latch behind.
  always_comb begin
    state_d    = state;
    winner_d   = winner;
    lat_addr_d = lat_addr;
    lat_we_d   = lat_we;
    err_d      = err;
    unique case (state)
      IDLE: begin
        if (bus.M0_Req | bus.M1_Req) begin
          winner_d   = sel;
          lat_addr_d = sel_addr;
          lat_we_d   = sel_we;
          if (addr_valid(sel_addr)) begin
            state_d = ACCESS;
            err_d   = 1'b0;
          end else begin
            state_d = RESP;
            err_d   = 1'b1;
          end
        end
      end
      ACCESS: begin
        if (bus.Bus_Ready) begin
          state_d = RESP;
          err_d   = 1'b0;
        end else if (tmo_hit) begin
          state_d = RESP;
          err_d   = 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered, so they align with the state they describe.
  always_comb begin
    gnt_d    = (state_d != IDLE) ? (winner_d ? 2'b10 : 2'b01) : 2'b00;
    strobe_d = (state_d == ACCESS);
    addr_d   = strobe_d ? lat_addr_d : 32'd0;
    we_d     = strobe_d & lat_we_d;
    done_d   = (state_d == RESP) ? gnt_d : 2'b00;
    merr_d   = done_d & {2{err_d}};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      gnt_q    <= 2'b00;
      done_q   <= 2'b00;
      merr_q   <= 2'b00;
      addr_q   <= 32'd0;
      we_q     <= 1'b0;
      strobe_q <= 1'b0;
    end else begin
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      merr_q   <= merr_d;
      addr_q   <= addr_d;
      we_q     <= we_d;
      strobe_q <= strobe_d;
    end
  end

  assign bus.M0_Gnt     = gnt_q[0];
  assign bus.M1_Gnt     = gnt_q[1];
  assign bus.M0_Done    = done_q[0];
  assign bus.M1_Done    = done_q[1];
  assign bus.M0_Err     = merr_q[0];
  assign bus.M1_Err     = merr_q[1];
  assign bus.Bus_Addr   = addr_q;
  assign bus.Bus_WE     = we_q;
  assign bus.Bus_Strobe = strobe_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed self-checking bench for bus_arbiter; outputs are sampled on the falling clock edge.
module tb_bus_arbiter;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  bus_arbiter_if bus_if ();

  bus_arbiter #(.TIMEOUT_CYCLES(16)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_if.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] flags();
    return {bus_if.M0_Gnt, bus_if.M1_Gnt, bus_if.M0_Done, bus_if.M1_Done,
            bus_if.M0_Err, bus_if.M1_Err, bus_if.Bus_Strobe, bus_if.Bus_WE};
  endfunction

  task automatic check_quiet(input string tag);
    check({tag, "_flags"}, 32'(flags()), 32'd0);
    check({tag, "_addr"}, bus_if.Bus_Addr, 32'd0);
  endtask

  typedef struct {
    logic [31:0] addr;
    logic        valid;
  } dec_vec_t;

  dec_vec_t dec_tab[6] = '{
    '{32'h0000_1FFC, 1'b1}, '{32'h0000_2000, 1'b0}, '{32'hFFFF_0000, 1'b1},
    '{32'hFFFF_2FFC, 1'b1}, '{32'hFFFF_3000, 1'b0}, '{32'hFFFE_F000, 1'b0}
  };

  initial begin
    int n;
    bit saw_done;
    int gseq[$];

    bus_if.M0_Req = 1'b0; bus_if.M0_Addr = '0; bus_if.M0_WE = 1'b0;
    bus_if.M1_Req = 1'b0; bus_if.M1_Addr = '0; bus_if.M1_WE = 1'b0;
    bus_if.Bus_Ready = 1'b0;

    tick(); tick();
    check_quiet("reset");
    reset_n = 1'b1;

    // Single read by M0, Ready already high (also high in IDLE, which must be ignored)
    bus_if.Bus_Ready = 1'b1;
    tick();
    check_quiet("idle_ready_ignored");
    bus_if.M0_Req = 1'b1; bus_if.M0_Addr = 32'h0000_0100; bus_if.M0_WE = 1'b0;
    tick();
    check("rd_strobe", bus_if.Bus_Strobe, 1);
    check("rd_addr", bus_if.Bus_Addr, 32'h0000_0100);
    check("rd_we", bus_if.Bus_WE, 0);
    check("rd_gnt", {bus_if.M1_Gnt, bus_if.M0_Gnt}, 2'b01);
    check("rd_no_done", bus_if.M0_Done, 0);
    bus_if.M0_Req = 1'b0;
    tick();
    check("rd_done", {bus_if.M0_Done, bus_if.M0_Err, bus_if.Bus_Strobe}, 3'b100);
    check("rd_resp_addr", bus_if.Bus_Addr, 32'd0);
    check("rd_resp_gnt", bus_if.M0_Gnt, 1);
    bus_if.Bus_Ready = 1'b0;
    tick();
    check_quiet("rd_back_idle");

    // M1 write to UART page, Ready delayed so Strobe lasts 4 cycles
    bus_if.M1_Req = 1'b1; bus_if.M1_Addr = 32'hFFFF_1004; bus_if.M1_WE = 1'b1;
    n = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (bus_if.M1_Done) break;
      if (bus_if.Bus_Strobe) begin
        n++;
        check("wr_addr_held", bus_if.Bus_Addr, 32'hFFFF_1004);
        check("wr_we", bus_if.Bus_WE, 1);
        check("wr_gnt", {bus_if.M1_Gnt, bus_if.M0_Gnt}, 2'b10);
        bus_if.M1_Req = 1'b0;
        bus_if.M1_Addr = 32'h8000_0000;
      end
      if (n == 4) bus_if.Bus_Ready = 1'b1;
    end
    check("wr_strobe_cycles", n, 4);
    check("wr_done", {bus_if.M1_Done, bus_if.M1_Err, bus_if.M0_Done, bus_if.Bus_Strobe}, 4'b1000);
    bus_if.Bus_Ready = 1'b0;
    tick();
    check_quiet("wr_back_idle");

    // Invalid address: no Strobe, error response on the cycle after the request is sampled
    bus_if.M0_Req = 1'b1; bus_if.M0_Addr = 32'h8000_0000;
    tick();
    check("inv_resp", {bus_if.M0_Done, bus_if.M0_Err, bus_if.M0_Gnt, bus_if.Bus_Strobe}, 4'b1110);
    bus_if.M0_Req = 1'b0;
    tick();
    check_quiet("inv_back_idle");

    // Decode boundaries
    for (int i = 0; i < 6; i++) begin
      bus_if.M0_Req = 1'b1; bus_if.M0_Addr = dec_tab[i].addr; bus_if.Bus_Ready = 1'b1;
      tick();
      check($sformatf("dec_%0h_strobe", dec_tab[i].addr), bus_if.Bus_Strobe, dec_tab[i].valid);
      check($sformatf("dec_%0h_err", dec_tab[i].addr),
            {bus_if.M0_Done, bus_if.M0_Err}, dec_tab[i].valid ? 2'b00 : 2'b11);
      bus_if.M0_Req = 1'b0;
      tick(); tick();
      bus_if.Bus_Ready = 1'b0;
      check_quiet($sformatf("dec_%0h_idle", dec_tab[i].addr));
    end

    // Round-robin from reset with both requests held
    reset_n = 1'b0;
    bus_if.M0_Req = 1'b1; bus_if.M0_Addr = 32'h0000_0010; bus_if.M0_WE = 1'b0;
    bus_if.M1_Req = 1'b1; bus_if.M1_Addr = 32'h0000_0020; bus_if.M1_WE = 1'b0;
    bus_if.Bus_Ready = 1'b1;
    tick();
    reset_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      tick();
      check("rr_one_gnt", 32'(bus_if.M0_Gnt & bus_if.M1_Gnt), 0);
      if (bus_if.Bus_Strobe) gseq.push_back(int'(bus_if.M1_Gnt));
    end
    check("rr_count", gseq.size(), 4);
    for (int i = 0; i < 4 && i < gseq.size(); i++)
      check($sformatf("rr_order_%0d", i), gseq[i], i % 2);
    bus_if.M0_Req = 1'b0; bus_if.M1_Req = 1'b0;
    tick(); tick(); tick();

    // Leave the pointer favouring M1, then abort an M0 access by reset
    bus_if.M0_Req = 1'b1; bus_if.M0_Addr = 32'h0000_0040;
    tick();
    bus_if.M0_Req = 1'b0;
    tick(); tick();
    bus_if.Bus_Ready = 1'b0;
    bus_if.M0_Req = 1'b1;
    tick();
    check("abort_in_access", bus_if.Bus_Strobe, 1);
    bus_if.M1_Req = 1'b1; bus_if.M1_Addr = 32'h0000_0080;
    #2 reset_n = 1'b0;
    #1 check_quiet("abort_immediate");
    tick();
    check_quiet("abort_no_done");
    reset_n = 1'b1;
    tick();
    check("abort_gnt_m0", {bus_if.M1_Gnt, bus_if.M0_Gnt}, 2'b01);
    bus_if.M0_Req = 1'b0; bus_if.M1_Req = 1'b0;

    // Ready never arrives
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    bus_if.M0_Req = 1'b1; bus_if.M0_Addr = 32'h0000_0200;
    n = 0;
    saw_done = 1'b0;
    repeat (100) begin
      tick();
      bus_if.M0_Req = 1'b0;
      if (bus_if.Bus_Strobe) n++;
      if (bus_if.M0_Done && !saw_done) begin
        saw_done = 1'b1;
        check("tmo_err", bus_if.M0_Err, 1);
      end
    end
`ifdef ARB_TIMEOUT_EN
    check("tmo_strobe_cycles", n, 16);
    check("tmo_done_seen", 32'(saw_done), 1);
`else
    check("hang_strobe_cycles", n, 100);
    check("hang_no_done", 32'(saw_done), 0);
`endif
    reset_n = 1'b0;
    tick();
    check_quiet("final_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
